// File: rtl/full_adder.sv
// Registered ripple-carry adder cell with carry, signed-overflow and zero flags.
// WIDTH=1 is the single-bit building block; wider instances chain per-bit cells.

// One bit of the ripple chain: sum and majority carry.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Overflow when carry into and out of the sign bit differ; for WIDTH=1
  // the carry into the sign bit is Cin itself.
  logic ovf;
  logic zro;
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
  assign zro = ~|sum;

  // Result registers: load on accepted input, hold otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= c[WIDTH];
        V    <= ovf;
        Z    <= zro;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench: stimulus pushes expected results computed arithmetically,
// per-DUT monitors pop and compare on out_valid and check hold/reset values.
module tb_full_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv1 = 1'b0, iv16 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        c1 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [0:0]  s1;
  logic [15:0] s16;
  logic        co1, v1, z1, ov1;
  logic        co16, v16, z16, ov16;

  int total = 0;
  int bad   = 0;

  exp_t q1[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .Cout(co1), .V(v1), .Z(z1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .A(a16), .B(b16), .Cin(c16),
    .S(s16), .Cout(co16), .V(v16), .Z(z16), .out_valid(ov16)
  );

  // Reference: plain integer arithmetic, signed overflow from range check.
  function automatic exp_t model(int w, longint unsigned a, longint unsigned b, bit cin);
    exp_t e;
    longint unsigned full, m;
    longint sa, sb, t, maxs, mins;
    m    = 64'd1 << w;
    full = a + b + cin;
    e.s  = full % m;
    e.c  = ((full / m) != 0);
    sa   = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    sb   = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    t    = sa + sb + cin;
    maxs = longint'(m / 2) - 1;
    mins = -longint'(m / 2);
    e.v  = (t > maxs) || (t < mins);
    e.z  = (e.s == 0);
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // What each edge should have done, as seen by the monitors.
  logic rs_seen = 1'b0, ev1 = 1'b0, ev16 = 1'b0;
  always @(posedge clk) begin
    rs_seen <= rst;
    ev1     <= iv1 & ~rst;
    ev16    <= iv16 & ~rst;
  end

  // WIDTH=1 monitor
  exp_t cur1;
  bit   go1 = 1'b0;
  always @(negedge clk) begin
    if (rs_seen) begin
      cur1 = '{s: 64'd0, c: 1'b0, v: 1'b0, z: 1'b1};
      go1  = 1'b1;
      chk("w1_rst_ovalid", {63'd0, ov1}, 64'd0);
    end else if (go1) begin
      chk("w1_ovalid", {63'd0, ov1}, {63'd0, ev1});
      if (ov1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL w1_unexpected got=result want=none t=%0t", $time);
        end else cur1 = q1.pop_front();
      end
    end
    if (go1) begin
      chk("w1_S", {63'd0, s1}, cur1.s);
      chk("w1_Cout", {63'd0, co1}, {63'd0, cur1.c});
      chk("w1_V", {63'd0, v1}, {63'd0, cur1.v});
      chk("w1_Z", {63'd0, z1}, {63'd0, cur1.z});
    end
  end

  // WIDTH=16 monitor
  exp_t cur16;
  bit   go16 = 1'b0;
  always @(negedge clk) begin
    if (rs_seen) begin
      cur16 = '{s: 64'd0, c: 1'b0, v: 1'b0, z: 1'b1};
      go16  = 1'b1;
      chk("w16_rst_ovalid", {63'd0, ov16}, 64'd0);
    end else if (go16) begin
      chk("w16_ovalid", {63'd0, ov16}, {63'd0, ev16});
      if (ov16) begin
        if (q16.size() == 0) begin
          total++; bad++;
          $display("FAIL w16_unexpected got=result want=none t=%0t", $time);
        end else cur16 = q16.pop_front();
      end
    end
    if (go16) begin
      chk("w16_S", {48'd0, s16}, cur16.s);
      chk("w16_Cout", {63'd0, co16}, {63'd0, cur16.c});
      chk("w16_V", {63'd0, v16}, {63'd0, cur16.v});
      chk("w16_Z", {63'd0, z16}, {63'd0, cur16.z});
    end
  end

  // Inputs are already set; record expectations, then advance one cycle.
  task automatic tick();
    if (!rst && iv1)  q1.push_back(model(1, a1, b1, c1));
    if (!rst && iv16) q16.push_back(model(16, a16, b16, c16));
    @(posedge clk);
    #1;
  endtask

  task automatic set1(bit v, bit a, bit b, bit c);
    iv1 = v; a1 = a; b1 = b; c1 = c;
  endtask

  task automatic set16(bit v, logic [15:0] a, logic [15:0] b, bit c);
    iv16 = v; a16 = a; b16 = b; c16 = c;
  endtask

  initial begin
    // Reset held two cycles with live inputs that must be discarded.
    rst = 1'b1;
    set1(1, 1, 1, 0);
    set16(1, 16'h1234, 16'h1111, 1);
    tick(); tick();
    rst = 1'b0;

    // First result after reset.
    set1(1, 1, 0, 0);
    set16(1, 16'hFFFF, 16'h0000, 1);   // carry ripples through all bits
    tick();

    // WIDTH=1 exhaustive, back-to-back; WIDTH=16 overflow cases alongside.
    for (int i = 0; i < 8; i++) begin
      set1(1, i[2], i[1], i[0]);
      case (i)
        0: set16(1, 16'h7FFF, 16'h0001, 0);
        1: set16(1, 16'h8000, 16'h8000, 0);
        2: set16(1, 16'h8000, 16'hFFFF, 0);
        3: set16(1, 16'h0000, 16'h0000, 0);
        default: set16(1, 16'($urandom), 16'($urandom), 1'($urandom));
      endcase
      tick();
    end

    // Hold: one accepted input then three idle cycles with changing inputs.
    set1(1, 1, 1, 1);
    set16(0, 16'h0, 16'h0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set1(0, 1'($urandom), 1'($urandom), 1'($urandom));
      set16(0, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end

    // WIDTH=16 streaming, WIDTH=1 random with occasional gaps.
    for (int i = 0; i < 100; i++) begin
      set16(1, 16'($urandom), 16'($urandom), 1'($urandom));
      set1(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    // Mid-stream reset, then resume.
    rst = 1'b1;
    set16(1, 16'hAAAA, 16'h5555, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set16(1, 16'($urandom), 16'($urandom), 1'($urandom));
      set1(1, 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    // Drain.
    set1(0, 0, 0, 0);
    set16(0, 16'h0, 16'h0, 0);
    tick(); tick(); tick();

    chk("w1_leftover", 64'(q1.size()), 64'd0);
    chk("w16_leftover", 64'(q16.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full-adder cell: computes A + B + Cin and presents sum and carry-out one clock after the inputs are sampled.
- WIDTH generalises the cell to a ripple-carry word adder. The default WIDTH=1 is the single-bit building block chained by the 16-bit adder (fa16bit).
- Also produces signed-overflow and zero flags so a word-level wrapper can take status directly from the cell.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A/B/Cin for sampling this cycle.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered sum, A + B + Cin modulo 2^WIDTH.
- Cout  output  1  registered carry out of MSB.
- V  output  1  registered signed overflow.
- Z  output  1  registered zero flag, 1 when S == 0.
- out_valid  output  1  high for one cycle when S/Cout/V/Z hold a new result.

Behaviour:
- Per-bit logic:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]
  - c[0] = Cin
  - Ripple through all WIDTH bits in one combinational pass.
- Cout = c[WIDTH].
- V = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, V = Cout ^ Cin.
- Z = (sum == 0). Evaluated on the sum only; carry is ignored.
- Latency is exactly 1 cycle:
  - On a rising edge with rst=0 and in_valid=1: register S, Cout, V, Z from the current inputs and set out_valid=1.
  - On a rising edge with rst=0 and in_valid=0: S/Cout/V/Z hold their previous values and out_valid=0.
- Reset: on a rising edge with rst=1, S=0, Cout=0, V=0, Z=1, out_valid=0.
  - Reset overrides in_valid on the same edge; inputs presented in a reset cycle are discarded.
  - Reset mid-stream drops any result not yet captured; the first valid input after rst deasserts yields out_valid on the following cycle.
- Back-to-back: in_valid held high produces one result per cycle, out_valid continuously high.
- No backpressure; a result is overwritten by the next accepted input.
- Wrap-around: the sum is truncated to WIDTH bits; the lost bit appears only in Cout.
- X/undriven inputs while in_valid=0 must not disturb the registered outputs.
- Outputs are driven only from flops, with no combinational path from inputs to outputs.

Test Plan:
- WIDTH=1 exhaustive: drive all 8 {A,B,Cin} combinations with in_valid=1. The next cycle must show S/Cout per the truth table (0,0,0->0,0; 1,0,0->1,0; 1,1,0->0,1; 1,1,1->1,1; ...), with out_valid=1 each cycle.
- Reset: assert rst for 2 cycles while in_valid=1, A=1, B=1. Outputs must read S=0, Cout=0, V=0, Z=1, out_valid=0. Deassert rst, apply A=1, B=0, Cin=0, then expect S=1, Z=0 one cycle later.
- Hold: apply A=1, B=1, Cin=1 with in_valid=1, then in_valid=0 with inputs changing for 3 cycles. S=1, Cout=1 must remain, and out_valid must be 1 for exactly one cycle.
- WIDTH=16 carry ripple: A=16'hFFFF, B=16'h0000, Cin=1 -> S=16'h0000, Cout=1, Z=1, V=0.
- WIDTH=16 signed overflow: A=16'h7FFF, B=16'h0001, Cin=0 -> S=16'h8000, Cout=0, V=1, Z=0. Then A=16'h8000, B=16'h8000 -> S=0, Cout=1, V=1, Z=1.
- WIDTH=16 streaming: 100 random {A,B,Cin} with in_valid=1 every cycle. Every result must match a reference model (A+B+Cin) one cycle later, with no gaps in out_valid.
